// File: rtl/ibuf_pkg.sv
// Shared types and sizing helpers for the ibuf loader.
// Provides the loader FSM state enum plus depth/counter-width functions.
package ibuf_pkg;

  typedef enum logic [1:0] {
    FILL,
    PAD,
    FULL
  } ibuf_ld_state_t;

  // Words per full ibuf buffer: two halves of fifo_length.
  function automatic int ibuf_depth(input int fl);
    return fl * 2;
  endfunction

  // Counter must reach DEPTH itself, hence DEPTH+1 codes.
  function automatic int ibuf_cnt_w(input int fl);
    return $clog2(fl * 2 + 1);
  endfunction

endpackage

// File: rtl/ibuf_loader.sv
// Feeds ibuf from a valid/ready word stream, zero-padding short vectors.
// Ports: clk, rstn (sync low), i_valid/o_ready/i_data/i_last in,
//        o_ibuf_we/o_ibuf_data to ibuf, o_full out, i_consume from tile.
module ibuf_loader
  import ibuf_pkg::*;
#(
  parameter int datatype_size = 8,
  parameter int fifo_length   = 5
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [datatype_size-1:0] i_data,
  input  logic                     i_last,
  output logic                     o_ibuf_we,
  output logic [datatype_size-1:0] o_ibuf_data,
  output logic                     o_full,
  input  logic                     i_consume
);

  localparam int DEPTH = ibuf_depth(fifo_length);
  localparam int CW    = ibuf_cnt_w(fifo_length);
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  ibuf_ld_state_t state, state_d;
  logic [CW-1:0]  cnt, cnt_d;

  logic                     run_q;
  logic                     we_q;
  logic [datatype_size-1:0] data_q;
  logic                     full_q;

  logic accept;
  logic consume;

  assign accept  = i_valid && o_ready;
  // Only a buffer the tile has been told about can be consumed.
  assign consume = i_consume && full_q && (state == FULL);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= FILL;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    unique case (state)
      FILL: begin
        if (accept) begin
          cnt_d = cnt + CW'(1);
          if (cnt == LAST) begin
            state_d = FULL;
          end else if (i_last) begin
            state_d = PAD;
          end
        end
      end
      PAD: begin
        cnt_d = cnt + CW'(1);
        if (cnt == LAST) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (consume) begin
          cnt_d   = '0;
          state_d = FILL;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = FILL;
      end
    endcase
  end

  // run_q keeps o_ready low through reset and for the release edge.
  always_comb begin
    o_ready = run_q && (state == FILL);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      run_q  <= 1'b0;
      we_q   <= 1'b0;
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      run_q  <= 1'b1;
      we_q   <= accept || (state == PAD);
      data_q <= accept ? i_data : '0;
      full_q <= (state == FULL) && !consume;
    end
  end

  assign o_ibuf_we   = we_q;
  assign o_ibuf_data = data_q;
  assign o_full      = full_q;

endmodule
